// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter: drives the register-file write port from two sources.
// The in-order pipeline always wins the slot. The auxiliary unit's results are
// queued in a small FIFO and drain on cycles the pipeline leaves free.
// A pipeline write squashes older queued writes to the same register, which
// keeps youngest-write-wins ordering. Busy flags expose live queued writes to decode.
// Optional macro WB_BYPASS_EN: an aux result that arrives with the FIFO empty
// and the slot free goes straight to the write port instead of being queued.
module reg_writeback_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_valid,
  input  logic [AW-1:0]            pipe_addr,
  input  logic [DW-1:0]            pipe_data,
  input  logic                     aux_valid,
  output logic                     aux_ready,
  input  logic [AW-1:0]            aux_addr,
  input  logic [DW-1:0]            aux_data,
  input  logic [AW-1:0]            qa,
  input  logic [AW-1:0]            qb,
  output logic                     qa_busy,
  output logic                     qb_busy,
  output logic                     wb_we,
  output logic [AW-1:0]            wb_addr,
  output logic [DW-1:0]            wb_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] live_q;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic pipe_take;
  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic bypass;
  logic push;
  logic pop;

  assign fifo_count = count;

  // Slot arbitration: a real pipeline write owns the slot, otherwise the FIFO head drains.
  always_comb begin
    pipe_take  = pipe_valid && (pipe_addr != '0);
    fifo_empty = (count == '0);
    fifo_full  = (count == CW'(DEPTH));
    aux_ready  = !fifo_full;
    accept     = aux_valid && !fifo_full;
`ifdef WB_BYPASS_EN
    bypass     = accept && fifo_empty && !pipe_take;
`else
    bypass     = 1'b0;
`endif
    push       = accept && !bypass;
    pop        = !pipe_take && !fifo_empty;
  end

  // Hazard query: look for a live, occupied entry that targets each query address.
  always_comb begin
    qa_busy = 1'b0;
    qb_busy = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (live_q[rd_ptr + PW'(i)] && (addr_q[rd_ptr + PW'(i)] == qa)) qa_busy = 1'b1;
        if (live_q[rd_ptr + PW'(i)] && (addr_q[rd_ptr + PW'(i)] == qb)) qb_busy = 1'b1;
      end
    end
    if (qa == '0) qa_busy = 1'b0;
    if (qb == '0) qb_busy = 1'b0;
  end

  // FIFO control state: pointers, occupancy and per-entry live bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      live_q <= '0;
    end else begin
      if (pipe_take) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (addr_q[i] == pipe_addr) live_q[i] <= 1'b0;
        end
      end
      // The pushed slot is free, so this later assignment wins over the squash loop;
      // a same-cycle pipe write to the same register is younger and squashes it here.
      if (push) begin
        live_q[wr_ptr] <= (aux_addr != '0) && !(pipe_take && (pipe_addr == aux_addr));
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO payload storage; needs no reset since live bits and occupancy gate its use.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= aux_addr;
      data_q[wr_ptr] <= aux_data;
    end
  end

  // Registered write port toward the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (pipe_take) begin
      wb_we   <= 1'b1;
      wb_addr <= pipe_addr;
      wb_data <= pipe_data;
    end else if (pop) begin
      wb_we   <= live_q[rd_ptr];
      wb_addr <= addr_q[rd_ptr];
      wb_data <= data_q[rd_ptr];
    end else if (bypass) begin
      wb_we   <= (aux_addr != '0);
      wb_addr <= aux_addr;
      wb_data <= aux_data;
    end else begin
      wb_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Self-checking bench for reg_writeback_arbiter: directed scenarios with
// literal expectations, then randomized traffic against a queue-based model.
module tb_reg_writeback_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pipe_valid = 1'b0;
  logic [AW-1:0] pipe_addr  = '0;
  logic [DW-1:0] pipe_data  = '0;
  logic          aux_valid  = 1'b0;
  logic          aux_ready;
  logic [AW-1:0] aux_addr   = '0;
  logic [DW-1:0] aux_data   = '0;
  logic [AW-1:0] qa = '0;
  logic [AW-1:0] qb = '0;
  logic          qa_busy;
  logic          qb_busy;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [2:0]    fifo_count;

  int errors = 0;
  int checks = 0;
  bit en = 1'b0;

  reg_writeback_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_addr(aux_addr), .aux_data(aux_data),
    .qa(qa), .qb(qb), .qa_busy(qa_busy), .qb_busy(qb_busy),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: queued aux writes plus the write-port register.
  typedef struct {
    bit            live;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit busy_of(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    foreach (q[i]) if (q[i].live && q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit take, acc, byp;
    ent_t e;
    take = pipe_valid && (pipe_addr != 0);
    acc  = aux_valid && (q.size() < DEPTH);
    byp  = 1'b0;
    if (take) foreach (q[i]) if (q[i].addr == pipe_addr) q[i].live = 1'b0;
    if (take) begin
      m_we = 1'b1; m_addr = pipe_addr; m_data = pipe_data;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      m_we = e.live; m_addr = e.addr; m_data = e.data;
    end
`ifdef WB_BYPASS_EN
    else if (acc) begin
      byp = 1'b1;
      m_we = (aux_addr != 0); m_addr = aux_addr; m_data = aux_data;
    end
`endif
    else m_we = 1'b0;
    if (acc && !byp) begin
      e.live = (aux_addr != 0) && !(take && pipe_addr == aux_addr);
      e.addr = aux_addr;
      e.data = aux_data;
      q.push_back(e);
    end
  endtask

  // Model advances on the same events as the design.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      model_step();
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (en) begin
      chk("wb_we", 64'(wb_we), 64'(m_we));
      chk("wb_addr", 64'(wb_addr), 64'(m_addr));
      chk("wb_data", 64'(wb_data), 64'(m_data));
      chk("fifo_count", 64'(fifo_count), 64'(q.size()));
      chk("aux_ready", 64'(aux_ready), 64'(q.size() < DEPTH));
      chk("qa_busy", 64'(qa_busy), 64'(busy_of(qa)));
      chk("qb_busy", 64'(qb_busy), 64'(busy_of(qb)));
    end
  end

  task automatic drive(input bit pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
    pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
    aux_valid  = av; aux_addr  = aa; aux_data  = ad;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pushed;
    bit acc;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    chk("reset_we", 64'(wb_we), 64'd0);
    chk("reset_addr", 64'(wb_addr), 64'd0);
    chk("reset_data", 64'(wb_data), 64'd0);
    chk("reset_count", 64'(fifo_count), 64'd0);
    chk("reset_ready", 64'(aux_ready), 64'd1);

    // Single pipeline write.
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    tick();
    chk("pipe_we", 64'(wb_we), 64'd1);
    chk("pipe_addr", 64'(wb_addr), 64'd5);
    chk("pipe_data", 64'(wb_data), 64'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("pipe_we_after", 64'(wb_we), 64'd0);

    // x0 writes from both sources are discarded.
    drive(1, 0, 32'h1234, 1, 0, 32'h55);
    tick();
    chk("x0_we1", 64'(wb_we), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("x0_we2", 64'(wb_we), 64'd0);
    chk("x0_count", 64'(fifo_count), 64'd0);

    // Pipe starves the FIFO until full, then drain order r1..r5.
    pushed = 0;
    for (int i = 0; i < 11; i++) begin
      drive(i < 6, 20, 32'(i), pushed < 5, AW'(pushed + 1), 32'(32'h100 + pushed + 1));
      acc = aux_ready && aux_valid;
      tick();
      if (acc) pushed++;
      if (i == 5) begin
        chk("full_count", 64'(fifo_count), 64'd4);
        chk("full_ready", 64'(aux_ready), 64'd0);
      end
      if (i >= 6) begin
        chk("drain_we", 64'(wb_we), 64'd1);
        chk("drain_addr", 64'(wb_addr), 64'(i - 5));
        chk("drain_data", 64'(wb_data), 64'(32'h100 + i - 5));
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Queued r7 squashed by a younger pipeline write.
    qa = 7;
    drive(0, 0, 0, 1, 7, 32'hA);
    tick();
`ifndef WB_BYPASS_EN
    chk("squash_busy_before", 64'(qa_busy), 64'd1);
`endif
    drive(1, 7, 32'hB, 0, 0, 0);
    tick();
    chk("squash_busy_after", 64'(qa_busy), 64'd0);
    chk("squash_we", 64'(wb_we), 64'd1);
    chk("squash_data", 64'(wb_data), 64'hB);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("squash_drain_we", 64'(wb_we), 64'd0);
    chk("squash_drain_count", 64'(fifo_count), 64'd0);

    // Same-cycle aux and pipe writes to r9.
    qb = 9;
    drive(1, 9, 32'd2, 1, 9, 32'd1);
    tick();
    chk("same_we", 64'(wb_we), 64'd1);
    chk("same_data", 64'(wb_data), 64'd2);
    chk("same_count", 64'(fifo_count), 64'd1);
    chk("same_busy", 64'(qb_busy), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("same_drain_we", 64'(wb_we), 64'd0);
    chk("same_drain_count", 64'(fifo_count), 64'd0);

    // Mid-cycle reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1, 20, 32'(i), 1, AW'(11 + i), 32'(i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_we", 64'(wb_we), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ready", 64'(aux_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_we", 64'(wb_we), 64'd0);
    end

`ifdef WB_BYPASS_EN
    drive(0, 0, 0, 1, 3, 32'h77);
    tick();
    chk("bypass_we", 64'(wb_we), 64'd1);
    chk("bypass_addr", 64'(wb_addr), 64'd3);
    chk("bypass_count", 64'(fifo_count), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 4, AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), $urandom);
      qa = AW'($urandom_range(0, 7));
      qb = AW'($urandom_range(0, 7));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (DEPTH + 2) tick();
    chk("final_count", 64'(fifo_count), 64'd0);

    en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
